// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the 4 KiB CHIP-8 main memory between the ROM/font
// loader (port 0), the CPU (port 1) and the debug port (port 2). It issues
// at most one RAM access per cycle, tags reads so their data returns with a
// per-port rvalid pulse, and lets a requester lock the memory for a burst.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration; when undefined, fixed priority port 0 > port 1 > port 2.
module mem_arbiter #(
    parameter int RD_LATENCY = 1,
    parameter int NPORTS     = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS-1:0]    lock,
    input  logic [NPORTS-1:0]    we,
    input  logic [12*NPORTS-1:0] addr,
    input  logic [8*NPORTS-1:0]  wdata,
    output logic [NPORTS-1:0]    gnt,
    output logic [NPORTS-1:0]    rvalid,
    output logic [7:0]           rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [11:0]          mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata
);

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } state_t;

    state_t            state;
    logic [NPORTS-1:0] lock_mask;
    logic [NPORTS-1:0] tag_pipe [RD_LATENCY];

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [1:0]        rr_ptr;
`endif

    logic [NPORTS-1:0] eligible;
    logic [NPORTS-1:0] open_pick;
    logic [NPORTS-1:0] win;
    logic              open_eval;
    logic [1:0]        start_idx;
    logic [11:0]       sel_addr;
    logic [7:0]        sel_wdata;

    // Choose this edge's winner: a port just granted sits out one edge, and
    // while locked only the owner may win until it drops lock off a grant cycle.
    always_comb begin
        eligible  = req & ~gnt;
        open_eval = (state == ST_OPEN) ||
                    (((lock & lock_mask) == '0) && ((gnt & lock_mask) == '0));
`ifdef MEM_ARB_ROUND_ROBIN_EN
        start_idx = rr_ptr;
`else
        start_idx = 2'd0;
`endif
        open_pick = '0;
        for (int k = 0; k < NPORTS; k++) begin
            int p;
            p = (int'(start_idx) + k) % NPORTS;
            if ((open_pick == '0) && eligible[p]) begin
                open_pick[p] = 1'b1;
            end
        end
        win       = open_eval ? open_pick : (eligible & lock_mask);
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (win[k]) begin
                sel_addr  = addr[12*k +: 12];
                sel_wdata = wdata[8*k +: 8];
            end
        end
    end

    // Register grant and RAM command; track lock ownership and the RR pointer.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= ST_OPEN;
            lock_mask <= '0;
            gnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_ptr    <= 2'd0;
`endif
        end else begin
            gnt    <= win;
            mem_en <= |win;
            mem_we <= |(win & we);
            if (|win) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            if (open_eval) begin
                if (|(win & lock)) begin
                    state     <= ST_LOCKED;
                    lock_mask <= win;
                end else begin
                    state     <= ST_OPEN;
                    lock_mask <= '0;
                end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (win[0]) begin
                    rr_ptr <= 2'd1;
                end else if (win[1]) begin
                    rr_ptr <= 2'd2;
                end else if (win[2]) begin
                    rr_ptr <= 2'd0;
                end
`endif
            end
        end
    end

    // Carry a one-hot port tag for every read alongside the RAM latency.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            tag_pipe[0] <= (mem_en && !mem_we) ? gnt : '0;
            for (int s = 1; s < RD_LATENCY; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    assign rvalid = tag_pipe[RD_LATENCY-1];
    assign rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a RAM model, a
// transaction-level reference model and literal expectations per scenario.
module tb_mem_arbiter;

    localparam int LAT = 3;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [2:0]  req, lock, we;
    logic [35:0] addr;
    logic [23:0] wdata;
    logic [2:0]  gnt, rvalid;
    logic [7:0]  rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        w;
        logic [11:0] a;
        logic [7:0]  d;
        logic        l;
    } txn_t;

    typedef struct {
        int         due;
        logic [2:0] port;
        logic [7:0] data;
    } ret_t;

    txn_t portq [3][$];
    ret_t rets [$];

    logic [7:0] ram [4096];
    logic [7:0] ram_pipe [LAT];
    logic [7:0] shadow [4096];

    int          cyc;
    int          owner;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    int          ptr;
`endif
    logic [2:0]  m_gnt, m_rvalid;
    logic        m_en, m_we;
    logic [11:0] m_addr;
    logic [7:0]  m_wdata, m_rdata;

    logic [2:0]  exp_seq [6];

    mem_arbiter #(.RD_LATENCY(LAT), .NPORTS(3)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Free-running system clock.
    always #5 clk_in = ~clk_in;

    // Synchronous RAM with LAT cycles from mem_en to read data.
    always @(posedge clk_in) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        ram_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : 8'h00;
        for (int s = 1; s < LAT; s++) ram_pipe[s] <= ram_pipe[s-1];
    end

    assign mem_rdata = ram_pipe[LAT-1];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        owner    = -1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        ptr      = 0;
`endif
        m_gnt    = '0;
        m_en     = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_rvalid = '0;
        rets.delete();
    endtask

    task automatic modelStep();
        logic [2:0] elig;
        int         win;
        int         start;
        bit         open_eval;
        cyc++;
        if (rst_in) begin
            modelReset();
            return;
        end
        elig      = req & ~m_gnt;
        win       = -1;
        open_eval = (owner < 0) || (!lock[owner] && !m_gnt[owner]);
        if (!open_eval) begin
            if (elig[owner]) win = owner;
        end else begin
            owner = -1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            start = ptr;
`else
            start = 0;
`endif
            for (int k = 0; k < 3; k++) begin
                if (win < 0 && elig[(start + k) % 3]) win = (start + k) % 3;
            end
            if (win >= 0) begin
                if (lock[win]) owner = win;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                ptr = (win + 1) % 3;
`endif
            end
        end
        m_gnt = '0;
        if (win >= 0) begin
            m_gnt[win] = 1'b1;
            m_en       = 1'b1;
            m_we       = we[win];
            m_addr     = addr[12*win +: 12];
            m_wdata    = wdata[8*win +: 8];
            if (m_we) shadow[m_addr] = m_wdata;
            else      rets.push_back('{cyc + LAT, m_gnt, shadow[m_addr]});
        end else begin
            m_en = 1'b0;
            m_we = 1'b0;
        end
        m_rvalid = '0;
        if (rets.size() > 0 && rets[0].due == cyc) begin
            m_rvalid = rets[0].port;
            m_rdata  = rets[0].data;
            void'(rets.pop_front());
        end
    endtask

    // An asynchronous reset pulse between edges also flushes the model.
    always @(posedge rst_in) modelReset();

    // Advance the model at every edge and compare DUT outputs shortly after.
    always @(posedge clk_in) begin
        modelStep();
        #1;
        checkOutput("cyc_gnt", gnt, m_gnt);
        checkOutput("cyc_rvalid", rvalid, m_rvalid);
        checkOutput("cyc_mem_en", mem_en, m_en);
        checkOutput("cyc_mem_we", mem_we, m_we);
        checkOutput("cyc_mem_addr", mem_addr, m_addr);
        checkOutput("cyc_mem_wdata", mem_wdata, m_wdata);
        if (m_rvalid != 0) checkOutput("cyc_rdata", rdata, m_rdata);
    end

    task automatic drivePorts();
        for (int i = 0; i < 3; i++) begin
            if (portq[i].size() > 0) begin
                req[i]            = 1'b1;
                lock[i]           = portq[i][0].l;
                we[i]             = portq[i][0].w;
                addr[12*i +: 12]  = portq[i][0].a;
                wdata[8*i +: 8]   = portq[i][0].d;
            end else begin
                req[i]  = 1'b0;
                lock[i] = 1'b0;
                we[i]   = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input int port, input logic w, input logic [11:0] a,
                                 input logic [7:0] d, input logic l);
        txn_t t;
        t.w = w;
        t.a = a;
        t.d = d;
        t.l = l;
        portq[port].push_back(t);
        drivePorts();
    endtask

    task automatic tick();
        @(negedge clk_in);
        for (int i = 0; i < 3; i++) begin
            if (gnt[i] && portq[i].size() > 0) void'(portq[i].pop_front());
        end
        drivePorts();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gnt"}, gnt, 0);
        checkOutput({tag, "_rvalid"}, rvalid, 0);
        checkOutput({tag, "_mem_en"}, mem_en, 0);
        checkOutput({tag, "_mem_we"}, mem_we, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    // Directed scenarios with hand-computed cycle expectations.
    initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
        exp_seq = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
`endif
        for (int i = 0; i < 4096; i++) begin
            ram[i]    = 8'(i) ^ 8'h5A;
            shadow[i] = 8'(i) ^ 8'h5A;
        end
        ram[12'h200]    = 8'h12;
        shadow[12'h200] = 8'h12;
        cyc    = 0;
        rst_in = 1'b1;
        req    = '0;
        lock   = '0;
        we     = '0;
        addr   = '0;
        wdata  = '0;
        modelReset();

        repeat (3) tick();
        checkAllZero("reset");
        rst_in = 1'b0;
        repeat (2) tick();

        $display("[TB] single read, port 1 at 0x200");
        applyStimulus(1, 1'b0, 12'h200, 8'h00, 1'b0);
        tick();
        checkOutput("s1_gnt", gnt, 3'b010);
        checkOutput("s1_mem_en", mem_en, 1);
        checkOutput("s1_mem_addr", mem_addr, 12'h200);
        tick();
        checkOutput("s1_gnt_gap", gnt, 3'b000);
        tick();
        tick();
        checkOutput("s1_rvalid", rvalid, 3'b010);
        checkOutput("s1_rdata", rdata, 8'h12);
        repeat (3) tick();

        $display("[TB] write by port 0 then read by port 2 at 0x050");
        applyStimulus(0, 1'b1, 12'h050, 8'hAB, 1'b0);
        tick();
        checkOutput("s2_gnt_wr", gnt, 3'b001);
        checkOutput("s2_mem_we", mem_we, 1);
        checkOutput("s2_mem_wdata", mem_wdata, 8'hAB);
        applyStimulus(2, 1'b0, 12'h050, 8'h00, 1'b0);
        tick();
        checkOutput("s2_gnt_rd", gnt, 3'b100);
        checkOutput("s2_mem_addr", mem_addr, 12'h050);
        tick();
        tick();
        checkOutput("s2_no_wr_rvalid", rvalid, 3'b000);
        tick();
        checkOutput("s2_rvalid", rvalid, 3'b100);
        checkOutput("s2_rdata", rdata, 8'hAB);
        repeat (3) tick();

        $display("[TB] three-way contention");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1'b0, 12'h100 + 12'(k), 8'h00, 1'b0);
            applyStimulus(1, 1'b0, 12'h180 + 12'(k), 8'h00, 1'b0);
            applyStimulus(2, 1'b0, 12'h1C0 + 12'(k), 8'h00, 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput($sformatf("s3_gnt%0d", k), gnt, exp_seq[k]);
        end
        repeat (16) tick();

        $display("[TB] locked burst by port 1");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 1'b0, 12'h300 + 12'(k), 8'h00, 1'b1);
        end
        tick();
        checkOutput("s4_gnt0", gnt, 3'b010);
        applyStimulus(0, 1'b0, 12'h010, 8'h00, 1'b0);
        applyStimulus(2, 1'b0, 12'h020, 8'h00, 1'b0);
        for (int k = 1; k < 10; k++) begin
            tick();
            checkOutput($sformatf("s4_gnt%0d", k), gnt, (k % 2 == 0) ? 3'b010 : 3'b000);
        end
        tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        checkOutput("s4_gnt_unlock", gnt, 3'b100);
`else
        checkOutput("s4_gnt_unlock", gnt, 3'b001);
`endif
        repeat (10) tick();

        $display("[TB] reset during an in-flight read");
        applyStimulus(2, 1'b0, 12'h050, 8'h00, 1'b0);
        tick();
        checkOutput("s5_gnt", gnt, 3'b100);
        tick();
        rst_in = 1'b1;
        #1;
        checkAllZero("s5_rst");
        #1;
        rst_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("s5_no_rvalid%0d", k), rvalid, 3'b000);
        end

        $display("[TB] read after reset, RAM contents survive");
        applyStimulus(0, 1'b0, 12'h050, 8'h00, 1'b0);
        tick();
        checkOutput("s6_gnt", gnt, 3'b001);
        repeat (3) tick();
        checkOutput("s6_rvalid", rvalid, 3'b001);
        checkOutput("s6_rdata", rdata, 8'hAB);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port arbiter that shares the 4 KiB CHIP-8 main memory between three requesters: port 0 (ROM/font loader), port 1 (CPU fetch, sprite and writeback traffic), port 2 (debug/inspection port). It sits between the requesters and the synchronous RAM. It issues at most one memory access per cycle, returns read data with a per-port valid pulse, and supports a lock so the CPU can keep the memory for a sprite fetch.

## Interface
Parameters:
- RD_LATENCY, 1: RAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..4.
- NPORTS, 3: number of requesters; fixed at 3 for this revision.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- req  input  3  per-port request; held with addr/we/wdata stable until the port sees gnt.
- lock  input  3  per-port lock; sampled with req.
- we  input  3  per-port write enable (1 = write, 0 = read).
- addr  input  36  packed addresses, port i at [12*i+11:12*i].
- wdata  input  24  packed write data, port i at [8*i+7:8*i].
- gnt  output  3  one-hot grant, registered; 1-cycle pulse.
- rvalid  output  3  one-hot read-return pulse.
- rdata  output  8  read data, valid only while some rvalid bit is high.
- mem_en  output  1  RAM access strobe, registered.
- mem_we  output  1  RAM write enable, registered.
- mem_addr  output  12  RAM address, registered.
- mem_wdata  output  8  RAM write data, registered.
- mem_rdata  input  8  RAM read data.

## Operation
- Eligibility at an edge: req[i]=1 and gnt[i]=0 in the current cycle. A port cannot be granted on two consecutive cycles.
- States:
  - OPEN: choose one eligible port by the policy in Configuration. If that port's lock is 1, go to LOCKED(i).
  - LOCKED(i): only port i is eligible. Leave for OPEN at the first edge where lock[i]=0 and gnt[i]=0. That edge is evaluated as OPEN, so other ports may win there.
- Grant edge: gnt[i], mem_en, mem_we=we[i], mem_addr=addr[i] and mem_wdata=wdata[i] are registered for one cycle. With no winner, mem_en=0, gnt=0, and mem_addr/mem_wdata hold their last values.
- Read tag pipeline: RD_LATENCY stages of {valid, port index}. Reads push a tag; writes push an invalid tag. rvalid[i] is high when the tag at the output stage is valid and equals i. rdata = mem_rdata combinationally.
- Simultaneous read and write to the same address from different ports: these are serialized by the grant order. The read returns the value the RAM holds at its own access cycle.
- Lock asserted by a port that is not in LOCKED: it only takes effect when that port wins.

## Timing
- Reset values: gnt=0, rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, state=OPEN, RR pointer=0, all tags invalid.
- Reset mid-operation: in-flight reads are discarded and produce no rvalid. A write already presented to the RAM is not retracted.
- Request to grant: req high before edge N, gnt and mem_en high during cycle N→N+1.
- Grant to rvalid: rvalid is high during cycle N+RD_LATENCY→N+RD_LATENCY+1.
- Throughput:
  - one access per cycle aggregate when two or more ports alternate;
  - one access every 2 cycles for a single port, locked or not.
- A port updates req/addr at the edge where it sees gnt. The arbiter ignores that port's inputs at that edge.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: round-robin selection. The search starts at the RR pointer and wraps 2→0. After a grant to port i, the pointer becomes (i+1) mod 3. The pointer is frozen while in LOCKED.
- Undefined: fixed priority, port 0 > port 1 > port 2. There is no pointer register.

## Test plan
- Single read: port 1 reads 0x200 (RAM holds 0x12), RD_LATENCY=1 → gnt[1] at cycle 1, mem_addr=0x200, rvalid[1] with rdata=0x12 at cycle 2.
- Write then read: port 0 writes 0xAB to 0x050, then port 2 reads 0x050 → gnt[0] then gnt[2] on the next cycle, rvalid[2] with rdata=0xAB. No rvalid for port 0.
- Contention, all three ports requesting continuously:
  - with MEM_ARB_ROUND_ROBIN_EN, grant order 0,1,2,0,1,2;
  - without it, grants alternate 0,1,0,1 and port 2 is never granted.
- Lock: port 1 reads 0x300..0x304 with lock=1 while ports 0 and 2 request → only gnt[1], on every other cycle, 5 grants. Port 0 or 2 is granted at the edge after lock drops.
- Reset mid-read: RD_LATENCY=3, assert rst_in one cycle after gnt[2] → no rvalid ever appears for that read, and all outputs read 0 during reset.
